// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory responder slice:
//   - DM_WORD_W        : data word width (16-bit RISC core)
//   - DM_DEF_*         : default depth / latency values for the responder
//   - dm_state_e       : responder FSM state encoding
//   - dm_max()         : helper used to size the latency counter
// -----------------------------------------------------------------------------
package dm_pkg;

   localparam int DM_WORD_W          = 16;
   localparam int DM_DEF_DEPTH_WORDS = 256;
   localparam int DM_DEF_READ_LAT    = 2;
   localparam int DM_DEF_WRITE_LAT   = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dm_state_e;

   function automatic int dm_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage : dm_pkg

// File: rtl/dm_word_ram.sv
// -----------------------------------------------------------------------------
// dm_word_ram
// Single-port word array: synchronous write, combinational read on the same
// address. Contents start at zero and are never cleared afterwards.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable (write happens on the rising edge)
//   addr   in   word index, clog2(DEPTH_WORDS) bits
//   wdata  in   write data, DM_WORD_W bits
//   rdata  out  word currently stored at addr
// -----------------------------------------------------------------------------
module dm_word_ram
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = DM_DEF_DEPTH_WORDS
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [DM_WORD_W-1:0]           wdata,
   output logic [DM_WORD_W-1:0]           rdata
);

   // NOTE: the storage array has no reset term; a reset loop over every word
   // would stop it mapping onto RAM. The declaration initialiser supplies the
   // all-zero power-up contents instead.
   logic [DM_WORD_W-1:0] mem_q [DEPTH_WORDS] = '{default: '0};

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule : dm_word_ram

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Responder for the core's data-memory port. Accepts one load/store at a time
// on a valid/ready request channel, waits READ_LAT / WRITE_LAT cycles, then
// presents the completion on a valid/ready response channel. Misaligned or
// out-of-range accesses complete with rsp_err=1, no write and rdata=0.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  responder accepts a request this cycle (IDLE only)
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address (word index = req_addr[15:1])
//   req_wdata  in   store data
//   rsp_valid  out  response present, held until rsp_ready
//   rsp_ready  in   initiator accepts the response
//   rsp_rdata  out  load data (0 for stores and errors)
//   rsp_err    out  access was misaligned or out of range
// -----------------------------------------------------------------------------
module data_mem_responder
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = DM_DEF_DEPTH_WORDS,
   parameter int READ_LAT    = DM_DEF_READ_LAT,
   parameter int WRITE_LAT   = DM_DEF_WRITE_LAT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [15:0]          req_addr,
   input  logic [DM_WORD_W-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DM_WORD_W-1:0] rsp_rdata,
   output logic                 rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(dm_max(READ_LAT, WRITE_LAT)) + 1;

   localparam logic [15:0]   DEPTH_LIMIT = 16'(DEPTH_WORDS);
   localparam logic [CW-1:0] RD_CNT_INIT = CW'(READ_LAT - 1);
   localparam logic [CW-1:0] WR_CNT_INIT = CW'(WRITE_LAT - 1);

   // Registered state and outputs
   dm_state_e              state_q,     state_d;
   logic [CW-1:0]          cnt_q,       cnt_d;
   logic                   write_q,     write_d;
   logic [AW-1:0]          idx_q,       idx_d;
   logic [DM_WORD_W-1:0]   wdata_q,     wdata_d;
   logic                   err_q,       err_d;
   logic                   req_ready_q, req_ready_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [DM_WORD_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                   rsp_err_q,   rsp_err_d;

   // Request decode
   logic                   req_fire;
   logic                   req_err;
   logic [AW-1:0]          req_idx;
   logic                   lat_one;

   // Access presented to storage on the edge that enters RESP. For a
   // single-cycle access that edge is the accept edge, so the live request
   // fields are used; otherwise the values latched at accept are used.
   logic                   in_idle;
   logic                   enter_resp;
   logic                   ent_write;
   logic                   ent_err;
   logic [AW-1:0]          ent_idx;
   logic [DM_WORD_W-1:0]   ent_wdata;

   logic                   ram_we;
   logic [DM_WORD_W-1:0]   ram_rdata;

   // req_ready_q is only ever 1 in IDLE, so a handshake implies IDLE.
   assign req_fire = req_valid & req_ready_q;
   assign req_idx  = req_addr[AW:1];
   assign req_err  = req_addr[0] | ({1'b0, req_addr[15:1]} >= DEPTH_LIMIT);
   assign lat_one  = req_write ? (WRITE_LAT == 1) : (READ_LAT == 1);

   assign in_idle    = (state_q == IDLE);
   assign enter_resp = (in_idle & req_fire & lat_one)
                     | ((state_q == WAIT) & (cnt_q == CW'(1)));

   assign ent_write = in_idle ? req_write : write_q;
   assign ent_err   = in_idle ? req_err   : err_q;
   assign ent_idx   = in_idle ? req_idx   : idx_q;
   assign ent_wdata = in_idle ? req_wdata : wdata_q;

   // Reset on the same edge cancels the commit: a store caught in WAIT (or
   // accepted on the reset edge) never reaches storage.
   assign ram_we = enter_resp & ent_write & ~ent_err & ~reset;

   dm_word_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ent_idx),
      .wdata (ent_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      // NOTE: every signal assigned here gets a hold-value default first, so
      // no path through the case leaves one unassigned and infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_fire) begin
               write_d     = req_write;
               idx_d       = req_idx;
               wdata_d     = req_wdata;
               err_d       = req_err;
               cnt_d       = req_write ? WR_CNT_INIT : RD_CNT_INIT;
               req_ready_d = 1'b0;
               state_d     = WAIT;   // overridden below when lat_one
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CW'(1);
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               req_ready_d = 1'b1;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b0;
            rsp_valid_d = 1'b0;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
         end
      endcase

      if (enter_resp) begin
         state_d     = RESP;
         rsp_valid_d = 1'b1;
         rsp_err_d   = ent_err;
         rsp_rdata_d = (!ent_write && !ent_err) ? ram_rdata : '0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values of the others, independent of statement order.
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule : data_mem_responder

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the datapath's data-memory interface: accepts load/store requests from the 16-bit RISC core over a valid/ready request channel and returns completions on a valid/ready response channel.
- Owns the word-organised data storage, applies configurable access latency, and flags misaligned or out-of-range accesses.
- Replaces the zero-latency data memory so the core (or a later multi-cycle control unit) can be exercised against realistic wait states.

Parameters:
- DEPTH_WORDS, 256, number of 16-bit words stored (power of two, 2..32768)
- READ_LAT, 2, cycles from request acceptance to read response (>=1)
- WRITE_LAT, 1, cycles from request acceptance to write response (>=1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  16  byte address
- req_wdata  in  16  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  16  load data (0 for stores and errors)
- rsp_err  out  1  access was misaligned or out of range

Behaviour:
- Clock and reset: clk only; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: req_ready=0 during the reset cycle, then 1. rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, latency counter=0.
- Storage contents are not cleared by reset. They are zero at time 0.
- Addressing: word index = req_addr[15:1]. Misaligned when req_addr[0]=1. Out of range when index >= DEPTH_WORDS. Either condition is an error.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid&req_ready at edge E, latch write, addr, wdata and error, and load counter = LAT-1, where LAT is the latency for the request type.
  - If LAT=1, go to RESP at E.
  - Otherwise go to WAIT.
- WAIT: req_ready=0. Counter decrements each cycle. When the counter reaches 1, go to RESP on the next edge.
- Latency rule: rsp_valid first rises exactly LAT cycles after E.
- Entering RESP:
  - Store without error: write the latched data to storage.
  - Load without error: rsp_rdata = storage word.
  - Error: no write, rsp_rdata=0, rsp_err=1.
- RESP: rsp_valid=1. rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid&rsp_ready. On that edge go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
- Ordering: one outstanding request. A new request is accepted no earlier than the cycle after the response handshake, so back-to-back throughput is LAT+1 cycles minimum.
- Read-after-write: a load accepted after a store's response completes returns the new data.
- req_valid ignored: req_valid while not in IDLE has no effect. The initiator holds the request until req_ready.
- Reset mid-operation: FSM goes to IDLE and outputs take reset values.
  - A store still in WAIT is dropped with no storage write.
  - A store already in RESP has committed.
- Simultaneous reset and handshake: reset wins.
- Width rules: no arithmetic on data. The counter width is clog2(max(READ_LAT,WRITE_LAT))+1.

Decomposition:
- Shared package dm_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), default latency constants, and a DM_WORD_W=16 constant.
- Sub-module dm_word_ram: single-port synchronous-write, combinational-read word array (DEPTH_WORDS x 16) with zero initial contents. The FSM, counter and error logic stay in data_mem_responder.

Test Plan:
- Store then load: store addr 0x0010 data 0xBEEF, then load 0x0010 -> store rsp 1 cycle after accept (err=0, rdata=0); load rsp exactly 2 cycles after accept with rdata=0xBEEF, err=0.
- Misaligned store: store 0x0011 data 0x1234, then load 0x0010 -> rsp_err=1 on the store; load returns the prior value 0xBEEF.
- Out-of-range load: load 0x0200 (index 256) -> rsp_err=1, rdata=0x0000, storage unchanged.
- Response backpressure: load with rsp_ready low for 3 cycles -> rsp_valid and rdata stable for all 3 cycles; req_ready=0 throughout; IDLE the cycle after the handshake.
- Reset mid-operation: with WRITE_LAT=3, store 0x0004=0x5A5A, assert reset in the WAIT cycle, then load 0x0004 -> load returns 0x0000; no response was emitted for the store.
- Busy ignores requests: assert a second req_valid during WAIT -> not accepted until req_ready=1. Responses arrive in order with the correct data.
